// File: rtl/mac_west_driver_pkg.sv
// Shared types and constants for the west-edge MAC array driver.
// Row instruction codes and controller state encoding.
package mac_west_driver_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  function automatic logic [1:0] op_inst(input logic op);
    return op ? INST_EXEC : INST_LOAD;
  endfunction

endpackage

// File: rtl/mac_west_driver_row_skew.sv
// Per-row launch register followed by a delay-deep skew line.
// Total latency is delay+1 cycles; reset clears every stage.
module row_skew #(
  parameter int delay = 0,
  parameter int w     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);

  logic [w-1:0] sr [delay+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= delay; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i <= delay; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[delay];

endmodule

// File: rtl/mac_west_driver.sv
// West-edge driver: issues command-length vectors into a systolic
// array with per-row skew, then drains for row cycles.
module mac_west_driver
  import mac_west_driver_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [len_bw-1:0] cmd_len,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [row*bw-1:0] in_data,
  output logic [row*bw-1:0] out_w,
  output logic [row*2-1:0]  inst_w,
  output logic              busy,
  output logic              done
);

  localparam int DW = (row > 1) ? $clog2(row) : 1;

  state_t            state, state_n;
  logic              op_q;
  logic [len_bw-1:0] len_q;
  logic [len_bw-1:0] cnt;
  logic [DW-1:0]     drain_cnt;
  logic              accept;
  logic              last_drain;
  logic [bw+1:0]     lane_d [row];
  logic [bw+1:0]     lane_q [row];

  assign accept     = in_vld && in_rdy;
  assign busy       = (state != S_IDLE);
  assign last_drain = (drain_cnt == DW'(row - 1));

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    in_rdy    = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_n = S_RUN;
      end
      S_RUN: begin
        in_rdy = (cnt < len_q);
        if (cnt == len_q)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_drain) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && cmd_valid) begin
        op_q  <= cmd_op;
        len_q <= cmd_len;
        cnt   <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Non-accepted cycles launch a zero bubble so rows stay in lockstep.
  for (genvar r = 0; r < row; r++) begin : g_row
    assign lane_d[r] = accept ?
      {op_inst(op_q), in_data[r*bw +: bw]} : '0;

    row_skew #(
      .delay (r),
      .w     (bw + 2)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .d     (lane_d[r]),
      .q     (lane_q[r])
    );
  end

  always_comb begin
    out_w  = '0;
    inst_w = '0;
    for (int r = 0; r < row; r++) begin
      out_w[r*bw +: bw] = lane_q[r][bw-1:0];
      inst_w[2*r +: 2]  = lane_q[r][bw +: 2];
    end
  end

endmodule

// File: tb/tb_mac_west_driver.sv
// Directed bench for mac_west_driver: captures per-cycle outputs and
// compares every row against hand-listed accept cycles.
module tb_mac_west_driver;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [5:0]  cmd_len;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] in_data;
  logic [31:0] out_w;
  logic [15:0] inst_w;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vec    [8];
  int          acc    [8];
  logic [31:0] h_out  [40];
  logic [15:0] h_inst [40];
  logic        h_done [40];
  logic        h_busy [40];
  logic        h_crdy [40];

  mac_west_driver #(
    .bw     (4),
    .row    (8),
    .len_bw (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .out_w     (out_w),
    .inst_w    (inst_w),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [5:0] len);
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Cycle 0 is the first RUN cycle; h_out/h_inst[c] hold cycle c values.
  task automatic capture(input logic [31:0] pat, input int ncyc,
                         input int drop, input int rst_at);
    int bi;
    bi = 0;
    for (int c = 0; c < ncyc; c++) begin
      in_vld  = pat[c];
      in_data = pat[c] ? vec[bi] : 32'hDEADBEEF;
      if (c == rst_at) reset = 1'b1;
      h_done[c] = done;
      h_busy[c] = busy;
      h_crdy[c] = cmd_ready;
      if (in_vld && in_rdy && bi < 7) bi++;
      tick();
      reset = 1'b0;
      if (c == drop) cmd_valid = 1'b0;
      h_out[c+1]  = out_w;
      h_inst[c+1] = inst_w;
    end
    in_vld  = 1'b0;
    in_data = '0;
  endtask

  task automatic verify(input string nm, input int ncyc, input int nb,
                        input logic [1:0] ei, input int d1,
                        input int d2, input int kill);
    logic [1:0] xi;
    logic [3:0] xd;
    logic [31:0] v;
    for (int c = 1; c < ncyc; c++) begin
      for (int r = 0; r < 8; r++) begin
        xi = 2'b00;
        xd = 4'h0;
        for (int k = 0; k < nb; k++) begin
          if (acc[k] + 1 + r == c && (kill < 0 || c <= kill)) begin
            v  = vec[k];
            xi = ei;
            xd = v[r*4 +: 4];
          end
        end
        check($sformatf("%s_inst_r%0d_c%0d", nm, r, c),
              32'(h_inst[c][2*r +: 2]), 32'(xi));
        check($sformatf("%s_data_r%0d_c%0d", nm, r, c),
              32'(h_out[c][r*4 +: 4]), 32'(xd));
      end
    end
    for (int c = 0; c < ncyc; c++)
      check($sformatf("%s_done_c%0d", nm, c), 32'(h_done[c]),
            32'(c == d1 || c == d2));
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_len   = '0;
    in_vld    = 1'b0;
    in_data   = '0;
    for (int i = 0; i < 8; i++) begin
      vec[i] = '0;
      acc[i] = 0;
    end
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_w",     out_w,             32'h0);
    check("rst_inst_w",    32'(inst_w),       32'h0);
    check("rst_cmd_ready", 32'(cmd_ready),    32'd1);
    check("rst_in_rdy",    32'(in_rdy),       32'd0);
    check("rst_busy",      32'(busy),         32'd0);
    check("rst_done",      32'(done),         32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_done",  32'(done),   32'd0);
      check("idle_out_w", out_w,       32'h0);
      check("idle_inst",  32'(inst_w), 32'h0);
    end

    // LOAD len=3, in_vld kept high past the last beat
    vec[0] = 32'h11111111;
    vec[1] = 32'h22222222;
    vec[2] = 32'h33333333;
    vec[3] = 32'hEEEEEEEE;
    acc[0] = 0; acc[1] = 1; acc[2] = 2;
    issue(1'b0, 6'd3);
    capture(32'h1F, 16, -1, -1);
    verify("load3", 16, 3, 2'b01, 11, -1, -1);
    check("load3_busy_after", 32'(h_busy[12]), 32'd0);
    check("load3_crdy_run",   32'(h_crdy[0]),  32'd0);

    // EXEC len=4 with a one-cycle in_vld gap after beat 2
    vec[0] = 32'h76543210;
    vec[1] = 32'hFEDCBA98;
    vec[2] = 32'h13579BDF;
    vec[3] = 32'h2468ACE0;
    acc[0] = 0; acc[1] = 1; acc[2] = 3; acc[3] = 4;
    issue(1'b1, 6'd4);
    capture(32'h1B, 18, -1, -1);
    verify("exec4", 18, 4, 2'b10, 13, -1, -1);
    for (int r = 0; r < 8; r++)
      check($sformatf("exec4_bubble_r%0d", r),
            32'(h_inst[3+r][2*r +: 2]), 32'd0);

    // zero-length command
    issue(1'b1, 6'd0);
    capture(32'h0, 12, -1, -1);
    verify("len0", 12, 0, 2'b10, 8, -1, -1);
    check("len0_busy_drain", 32'(h_busy[8]), 32'd1);
    check("len0_busy_after", 32'(h_busy[9]), 32'd0);

    // reset two cycles into EXEC len=6
    vec[0] = 32'h5A5A5A5A;
    vec[1] = 32'hA5A5A5A5;
    vec[2] = 32'h77777777;
    acc[0] = 0; acc[1] = 1;
    issue(1'b1, 6'd6);
    capture(32'hFFFF, 14, -1, 2);
    verify("abort", 14, 2, 2'b10, -1, -1, 2);
    check("abort_busy", 32'(h_busy[3]), 32'd0);
    check("abort_crdy", 32'(h_crdy[3]), 32'd1);

    vec[0] = 32'h9ABCDEF0;
    acc[0] = 0;
    issue(1'b0, 6'd1);
    capture(32'h1, 14, -1, -1);
    verify("post", 14, 1, 2'b01, 9, -1, -1);

    // cmd_valid held while busy; changed op/len must not leak in
    vec[0] = 32'h0F0F0F0F;
    vec[1] = 32'hF0F0F0F0;
    acc[0] = 0; acc[1] = 1;
    issue(1'b0, 6'd2);
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    cmd_len   = 6'd0;
    capture(32'h3, 24, 11, -1);
    verify("hold", 24, 2, 2'b01, 10, 20, -1);
    check("hold_crdy_run",  32'(h_crdy[0]),  32'd0);
    check("hold_crdy_idle", 32'(h_crdy[11]), 32'd1);
    check("hold_busy_11",   32'(h_busy[11]), 32'd0);
    check("hold_busy_12",   32'(h_busy[12]), 32'd1);
    check("hold_busy_21",   32'(h_busy[21]), 32'd0);
    check("hold_busy_22",   32'(h_busy[22]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
